// File: rtl/reg_status_file_pkg.sv
// Shared widths and constants for the architectural register file and its
// per-register rename-tag table.
package reg_status_file_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int TAG_W = 5;
    localparam int NUM_RD_PORTS = 2;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } cmt_req_t;

    typedef struct packed {
        logic [XLEN-1:0]  val;
        logic [TAG_W-1:0] tag;
    } rd_rsp_t;
endpackage

// File: rtl/reg_status_read_port.sv
// One source-operand lookup: x0 forcing and same-cycle commit bypass applied
// on top of the stored value/tag already selected by the top.
module reg_status_read_port
    import reg_status_file_pkg::*;
(
    input  logic [REG_W-1:0] idx,
    input  logic [XLEN-1:0]  cur_val,
    input  logic [TAG_W-1:0] cur_tag,
    input  cmt_req_t         cmt,
    output rd_rsp_t          rsp
);
    logic hit;

    // A commit only resolves the read if it is the producer the table still
    // points at; a younger rename keeps the operand pending.
    assign hit = cmt.vld && (cmt.rd == idx) && (cur_tag == cmt.tag);

    always_comb begin
        rsp.val = cur_val;
        rsp.tag = cur_tag;
        if (idx == REG_ZERO) begin
            rsp.val = '0;
            rsp.tag = TAG_NONE;
        end else if (hit) begin
            rsp.val = cmt.val;
            rsp.tag = TAG_NONE;
        end
    end
endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with rename-tag table: two combinational
// operand lookups, ROB commit writes, issue renames and flush.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             ren_vld,
    input  logic [REG_W-1:0] ren_rd,
    input  logic [TAG_W-1:0] ren_tag,
    input  logic             cmt_vld,
    input  logic [REG_W-1:0] cmt_rd,
    input  logic [TAG_W-1:0] cmt_tag,
    input  logic [XLEN-1:0]  cmt_val,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    output logic [XLEN-1:0]  rs1_val,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_val,
    output logic [TAG_W-1:0] rs2_tag
);
    logic [NREG-1:0][XLEN-1:0]  val_q;
    logic [NREG-1:0][TAG_W-1:0] tag_q;

    cmt_req_t cmt;
    assign cmt = '{vld: cmt_vld, rd: cmt_rd, tag: cmt_tag, val: cmt_val};

    logic [NUM_RD_PORTS-1:0][REG_W-1:0] rd_idx;
    rd_rsp_t [NUM_RD_PORTS-1:0]         rd_rsp;
    assign rd_idx = {rs2_idx, rs1_idx};

    genvar p;
    generate
        for (p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
            reg_status_read_port u_port (
                .idx     (rd_idx[p]),
                .cur_val (val_q[rd_idx[p]]),
                .cur_tag (tag_q[rd_idx[p]]),
                .cmt     (cmt),
                .rsp     (rd_rsp[p])
            );
        end
    endgenerate

    assign rs1_val = rd_rsp[0].val;
    assign rs1_tag = rd_rsp[0].tag;
    assign rs2_val = rd_rsp[1].val;
    assign rs2_tag = rd_rsp[1].tag;

    logic cmt_wr, ren_wr;
    assign cmt_wr = cmt_vld && (cmt_rd != REG_ZERO);
    assign ren_wr = ren_vld && (ren_rd != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            tag_q <= '0;
        end else if (rdy) begin
            // The ROB retires its head before a flush resets it, so val still lands.
            if (cmt_wr)
                val_q[cmt_rd] <= cmt_val;
            if (flush) begin
                tag_q <= '0;
            end else begin
                if (cmt_wr && (tag_q[cmt_rd] == cmt_tag))
                    tag_q[cmt_rd] <= TAG_NONE;
                // Later assignment: a same-cycle rename overrides the clear.
                if (ren_wr)
                    tag_q[ren_rd] <= ren_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            assert (!(ren_vld && !flush) || ren_tag != TAG_NONE);
            assert (!cmt_vld || cmt_tag != TAG_NONE);
        end
    end
endmodule
